// File: rtl/aes128_key_sched_ctrl.sv
// Iterative AES-128 key expansion. Optional build macro AES_KS_ZEROIZE_EN adds the zeroize_i input.
// Latency: accept edge T0, round k is written on edge Tk, and keys_ok_o/done_o follow edge T10. Read is 1 cycle (RD_REG=1) or 0 (RD_REG=0).
// Backpressure: key_ready_o is low during expansion. An offered key is ignored then and must be held by the source.
module aes128_key_sched_ctrl #(
  parameter int NR     = 10,
  parameter bit RD_REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef AES_KS_ZEROIZE_EN
  input  logic         zeroize_i,
`endif
  input  logic         key_valid_i,
  output logic         key_ready_o,
  input  logic [0:127] keyin,
  output logic         busy_o,
  output logic         done_o,
  output logic         keys_ok_o,
  input  logic [3:0]   rd_round_i,
  output logic [0:127] rd_key_o,
  output logic         rd_valid_o
);

  // AES-128 always has 10 rounds. Any other value is rejected while the design elaborates.
  if (NR != 10) begin : g_bad_nr
    $error("aes128_key_sched_ctrl: NR must be 10 for AES-128");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_READY  = 2'd2
  } state_t;

  // FIPS-197 forward S-box, indexed by input byte.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // SubWord applies the S-box to each byte. Four lookups form the only S-box datapath.
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // The round constant sits in the most significant byte. Round 0 and out-of-range values give 0.
  function automatic logic [31:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return {c, 24'h0};
  endfunction

  state_t       state_q, state_d;
  logic [0:127] store [0:10];
  // rcnt counts the rounds already written for the current key. It is 0 when no key is held.
  logic [3:0]   rcnt;
  logic         keys_ok_q;
  logic         done_q;
  logic         zero_req;
  logic         accept;
  logic         last_round;

`ifdef AES_KS_ZEROIZE_EN
  assign zero_req = zeroize_i;
`else
  assign zero_req = 1'b0;
`endif

  // Zeroize wins over a key accept that arrives on the same edge. The offered key is dropped.
  assign accept     = key_valid_i && (state_q != S_EXPAND) && !zero_req;
  assign last_round = (state_q == S_EXPAND) && (rcnt == 4'd10);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic plus the handshake and busy decode.
  always_comb begin
    state_d     = state_q;
    key_ready_o = 1'b1;
    busy_o      = 1'b0;
    case (state_q)
      S_IDLE, S_READY: begin
        if (accept) state_d = S_EXPAND;
      end
      S_EXPAND: begin
        key_ready_o = 1'b0;
        busy_o      = 1'b1;
        if (last_round) state_d = S_READY;
      end
      default: state_d = S_IDLE;
    endcase
    if (zero_req) state_d = S_IDLE;
  end

  // One expansion step: read the previous round key and derive the next one.
  logic [0:127] prev_key;
  logic [0:127] next_key;
  logic [3:0]   prev_idx;
  logic [31:0]  t_word, n0, n1, n2, n3, w3;
  always_comb begin
    prev_idx = rcnt - 4'd1;
    prev_key = '0;
    for (int i = 0; i <= 10; i++) begin
      if (prev_idx == 4'(i)) prev_key = store[i];
    end
    w3       = prev_key[96:127];
    t_word   = sub_word({w3[23:0], w3[31:24]}) ^ rcon(rcnt);
    n0       = prev_key[0:31]  ^ t_word;
    n1       = prev_key[32:63] ^ n0;
    n2       = prev_key[64:95] ^ n1;
    n3       = w3              ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  // Key store, round counter and status flags. Reset and zeroize both wipe the key material.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= 10; i++) store[i] <= '0;
      rcnt      <= 4'd0;
      keys_ok_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (zero_req) begin
        for (int i = 0; i <= 10; i++) store[i] <= '0;
        rcnt      <= 4'd0;
        keys_ok_q <= 1'b0;
      end else if (accept) begin
        store[0]  <= keyin;
        rcnt      <= 4'd1;
        keys_ok_q <= 1'b0;
      end else if (state_q == S_EXPAND) begin
        for (int i = 1; i <= 10; i++) begin
          if (rcnt == 4'(i)) store[i] <= next_key;
        end
        rcnt <= rcnt + 4'd1;
        if (last_round) begin
          keys_ok_q <= 1'b1;
          done_q    <= 1'b1;
        end
      end
    end
  end

  assign keys_ok_o = keys_ok_q;
  assign done_o    = done_q;

  // Read mux. Out-of-range indices read as zero. A round written on this edge still shows its old contents.
  logic [0:127] rd_key_c;
  logic         rd_valid_c;
  always_comb begin
    rd_key_c = '0;
    for (int i = 0; i <= 10; i++) begin
      if (rd_round_i == 4'(i)) rd_key_c = store[i];
    end
  end
  assign rd_valid_c = (rd_round_i < rcnt) && (rd_round_i <= 4'd10);

  if (RD_REG) begin : g_rd_reg
    logic [0:127] rd_key_q;
    logic         rd_valid_q;
    // Register the read data and its valid flag together so they describe the same sampled index.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_key_q   <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_key_q   <= rd_key_c;
        rd_valid_q <= rd_valid_c;
      end
    end
    assign rd_key_o   = rd_key_q;
    assign rd_valid_o = rd_valid_q;
  end else begin : g_rd_comb
    assign rd_key_o   = rd_key_c;
    assign rd_valid_o = rd_valid_c;
  end

endmodule

// File: tb/tb_aes128_key_sched_ctrl.sv
// Directed bench for aes128_key_sched_ctrl with the default RD_REG=1 read port.
module tb_aes128_key_sched_ctrl;

  logic         clk;
  logic         rst_n;
  logic         zeroize;
  logic         key_valid_i;
  logic         key_ready_o;
  logic [0:127] keyin;
  logic         busy_o;
  logic         done_o;
  logic         keys_ok_o;
  logic [3:0]   rd_round_i;
  logic [0:127] rd_key_o;
  logic         rd_valid_o;

  aes128_key_sched_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef AES_KS_ZEROIZE_EN
    .zeroize_i   (zeroize),
`endif
    .key_valid_i (key_valid_i),
    .key_ready_o (key_ready_o),
    .keyin       (keyin),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .keys_ok_o   (keys_ok_o),
    .rd_round_i  (rd_round_i),
    .rd_key_o    (rd_key_o),
    .rd_valid_o  (rd_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  localparam logic [0:127] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] A_R5  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
  localparam logic [0:127] A_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  typedef struct {
    bit           ksel;
    logic [3:0]   rnd;
    logic [0:127] exp_key;
    logic         exp_vld;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a key for one edge. The caller checks whether it was taken.
  task automatic offer(input logic [0:127] k);
    keyin       = k;
    key_valid_i = 1'b1;
    tick();
    key_valid_i = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [3:0] r,
                          input logic [0:127] k, input logic v);
    rd_round_i = r;
    tick();
    chk({name, " key"}, rd_key_o, k);
    chk({name, " vld"}, rd_valid_o, v);
  endtask

  task automatic run_table(input bit ks);
    for (int i = 0; i < 19; i++) begin
      if (tbl[i].ksel == ks)
        read_chk($sformatf("tbl%0d r%0d", i, tbl[i].rnd), tbl[i].rnd, tbl[i].exp_key, tbl[i].exp_vld);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b0, 4'd0,  KEY_A, 1'b1};
    tbl[1]  = '{1'b0, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605, 1'b1};
    tbl[2]  = '{1'b0, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f, 1'b1};
    tbl[3]  = '{1'b0, 4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b, 1'b1};
    tbl[4]  = '{1'b0, 4'd4,  128'hef44a541a8525b7fb671253bdb0bad00, 1'b1};
    tbl[5]  = '{1'b0, 4'd5,  A_R5, 1'b1};
    tbl[6]  = '{1'b0, 4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd, 1'b1};
    tbl[7]  = '{1'b0, 4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f, 1'b1};
    tbl[8]  = '{1'b0, 4'd8,  128'head27321b58dbad2312bf5607f8d292f, 1'b1};
    tbl[9]  = '{1'b0, 4'd9,  128'hac7766f319fadc2128d12941575c006e, 1'b1};
    tbl[10] = '{1'b0, 4'd10, A_R10, 1'b1};
    tbl[11] = '{1'b0, 4'd11, 128'h0, 1'b0};
    tbl[12] = '{1'b0, 4'd12, 128'h0, 1'b0};
    tbl[13] = '{1'b0, 4'd15, 128'h0, 1'b0};
    tbl[14] = '{1'b1, 4'd0,  KEY_B, 1'b1};
    tbl[15] = '{1'b1, 4'd1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe, 1'b1};
    tbl[16] = '{1'b1, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b1};
    tbl[17] = '{1'b1, 4'd12, 128'h0, 1'b0};
    tbl[18] = '{1'b1, 4'd11, 128'h0, 1'b0};

    rst_n = 1'b0; zeroize = 1'b0; key_valid_i = 1'b0; keyin = '0; rd_round_i = 4'd0;
    #23;
    chk("reset key_ready", key_ready_o, 1'b1);
    chk("reset busy", busy_o, 1'b0);
    chk("reset keys_ok", keys_ok_o, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("reset done", done_o, 1'b0);
    chk("reset rd_key", rd_key_o, 128'h0);
    chk("reset rd_vld", rd_valid_o, 1'b0);

    // Key A: poll round 5, and offer key B at T4. That key must be ignored.
    rd_round_i = 4'd5;
    offer(KEY_A);
    chk("A T0 busy", busy_o, 1'b1);
    chk("A T0 key_ready", key_ready_o, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      if (k == 4) begin
        keyin = KEY_B; key_valid_i = 1'b1;
        chk("A T4 key_ready", key_ready_o, 1'b0);
      end
      tick();
      key_valid_i = 1'b0;
      chk($sformatf("A T%0d poll5 vld", k), rd_valid_o, k >= 6);
      if (k >= 6) chk($sformatf("A T%0d poll5 key", k), rd_key_o, A_R5);
      chk($sformatf("A T%0d done", k), done_o, k == 10);
      chk($sformatf("A T%0d keys_ok", k), keys_ok_o, k == 10);
      chk($sformatf("A T%0d busy", k), busy_o, k < 10);
    end
    tick();
    chk("A T11 done", done_o, 1'b0);
    chk("A T11 keys_ok", keys_ok_o, 1'b1);
    chk("A T11 key_ready", key_ready_o, 1'b1);
    run_table(1'b0);

    // Rekey from READY with key B while watching round 10 lose its valid flag.
    rd_round_i = 4'd10;
    offer(KEY_B);
    chk("B T0 keys_ok", keys_ok_o, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) chk("B T1 old r10 vld", rd_valid_o, 1'b0);
      chk($sformatf("B T%0d keys_ok", k), keys_ok_o, k == 10);
      chk($sformatf("B T%0d done", k), done_o, k == 10);
    end
    run_table(1'b1);

    // Reset at T6 of a fresh expansion aborts it and wipes the store.
    rd_round_i = 4'd0;
    offer(KEY_A);
    for (int k = 1; k <= 6; k++) tick();
    rst_n = 1'b0;
    #1;
    chk("rst6 key_ready", key_ready_o, 1'b1);
    chk("rst6 busy", busy_o, 1'b0);
    chk("rst6 keys_ok", keys_ok_o, 1'b0);
    chk("rst6 done", done_o, 1'b0);
    chk("rst6 rd_key", rd_key_o, 128'h0);
    chk("rst6 rd_vld", rd_valid_o, 1'b0);
    #3;
    rst_n = 1'b1;
    begin
      bit saw_done = 1'b0;
      for (int k = 0; k < 12; k++) begin
        tick();
        if (done_o) saw_done = 1'b1;
      end
      chk("rst6 no done pulse", saw_done, 1'b0);
    end
    read_chk("rst6 r0", 4'd0, 128'h0, 1'b0);
    read_chk("rst6 r5", 4'd5, 128'h0, 1'b0);

`ifdef AES_KS_ZEROIZE_EN
    offer(KEY_A);
    for (int k = 1; k <= 10; k++) tick();
    chk("zz pre keys_ok", keys_ok_o, 1'b1);
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    chk("zz keys_ok", keys_ok_o, 1'b0);
    chk("zz key_ready", key_ready_o, 1'b1);
    chk("zz busy", busy_o, 1'b0);
    read_chk("zz r0", 4'd0, 128'h0, 1'b0);
    read_chk("zz r10", 4'd10, 128'h0, 1'b0);
    zeroize = 1'b1;
    offer(KEY_B);
    zeroize = 1'b0;
    chk("zz+acc busy", busy_o, 1'b0);
    chk("zz+acc key_ready", key_ready_o, 1'b1);
    tick();
    read_chk("zz+acc r0", 4'd0, 128'h0, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
